// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request/response bus between one requester and one memory
//
// Purpose: carries a valid/ready request channel (addr, wdata, wmask; wmask of
// zero means read) and a zero-handshake response channel (rdata, rvalid).
// The same interface type serves the instruction port, the data port and the
// unified memory port of mem_arbiter.
//
// Signals:
//   ready   memory side accepts the request this cycle
//   valid   request valid, held with its payload until ready
//   addr    request address            (Xlen)
//   wdata   request write data         (Xlen)
//   wmask   request byte write mask    (MaskBits)
//   rdata   response data              (Xlen)
//   rvalid  response valid, one pulse per accepted request, in order
//
// Modports: master = requester side, slave = memory side.
interface mem_arbiter_if #(
  parameter int Xlen     = 32,
  parameter int MaskBits = Xlen / 8
);
  logic                ready;
  logic                valid;
  logic [Xlen-1:0]     addr;
  logic [Xlen-1:0]     wdata;
  logic [MaskBits-1:0] wmask;
  logic [Xlen-1:0]     rdata;
  logic                rvalid;

  modport master (
    output valid, addr, wdata, wmask,
    input  ready, rdata, rvalid
  );

  modport slave (
    input  valid, addr, wdata, wmask,
    output ready, rdata, rvalid
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - merges instruction and data request ports onto one memory bus
//
// Purpose: round-robin arbitration between the core's instruction and data
// ports with a stalled grant held stable until the memory accepts it. An
// in-order source-ID FIFO records who issued each accepted request so every
// memory response is routed back, combinationally, to its requester.
//
// Configuration macro: MEM_ARB_DATA_PRIO_EN - when defined the data port wins
// every contention in IDLE (fixed priority); otherwise round-robin.
//
// Ports:
//   clk_i  clock
//   rst_i  asynchronous active-high reset
//   imem   slave  - instruction requester (source ID 0)
//   dmem   slave  - data requester        (source ID 1)
//   mem    master - unified memory bus
module mem_arbiter #(
  parameter int Xlen     = 32,
  parameter int MaskBits = Xlen / 8,
  parameter int Depth    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  mem_arbiter_if.slave  imem,
  mem_arbiter_if.slave  dmem,
  mem_arbiter_if.master mem
);
  localparam int AW = (Depth > 1) ? $clog2(Depth) : 1;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  localparam logic SRC_I = 1'b0;
  localparam logic SRC_D = 1'b1;

  logic [0:0]  state;
  logic        lock_src;
  logic        fifo_mem [Depth];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

`ifndef MEM_ARB_DATA_PRIO_EN
  // Port preferred on the next contention: 1 = data.
  logic        rr_pref;
`endif

  logic eligible;
  logic winner;
  logic sel_src;
  logic grant;
  logic push;
  logic pop;
  logic head;

  assign eligible = (count < (AW+1)'(Depth));

  always_comb begin
    // With a single requester the data valid alone decides the winner ID.
    winner = dmem.valid;
    if (imem.valid && dmem.valid) begin
`ifdef MEM_ARB_DATA_PRIO_EN
      winner = SRC_D;
`else
      winner = rr_pref;
`endif
    end
  end

  // HOLD never re-arbitrates; it is only entered while eligible and nothing
  // is pushed there, so it needs no eligibility term.
  assign sel_src = (state == ST_HOLD) ? lock_src : winner;
  assign grant   = !rst_i &&
                   ((state == ST_HOLD) || (eligible && (imem.valid || dmem.valid)));
  assign push    = grant && mem.ready;

  assign mem.valid = grant;
  assign mem.addr  = !grant ? '0 : (sel_src ? dmem.addr  : imem.addr);
  assign mem.wdata = !grant ? '0 : (sel_src ? dmem.wdata : imem.wdata);
  assign mem.wmask = !grant ? '0 : (sel_src ? dmem.wmask : imem.wmask);

  assign imem.ready = push && (sel_src == SRC_I);
  assign dmem.ready = push && (sel_src == SRC_D);

  // Responses with nothing outstanding are dropped.
  assign head = fifo_mem[rd_ptr];
  assign pop  = !rst_i && mem.rvalid && (count != '0);

  assign imem.rvalid = pop && (head == SRC_I);
  assign dmem.rvalid = pop && (head == SRC_D);
  assign imem.rdata  = imem.rvalid ? mem.rdata : '0;
  assign dmem.rdata  = dmem.rvalid ? mem.rdata : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= ST_IDLE;
      lock_src <= SRC_I;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
`ifndef MEM_ARB_DATA_PRIO_EN
      rr_pref  <= SRC_D;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant && !mem.ready) begin
            state    <= ST_HOLD;
            lock_src <= winner;
          end
        end
        default: begin
          if (mem.ready) state <= ST_IDLE;
        end
      endcase

      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
`ifndef MEM_ARB_DATA_PRIO_EN
        rr_pref <= ~sel_src;
`endif
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);

      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Source-ID storage needs no reset: the pointers and count define validity.
  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr] <= sel_src;
  end

`ifndef SYNTHESIS
  a_rvalid_outstanding: assert property (
    @(posedge clk_i) disable iff (rst_i) mem.rvalid |-> (count != '0)
  ) else $warning("mem_rvalid_i with no outstanding request; response dropped");
`endif
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter against a queue-based model
module tb_mem_arbiter;
  localparam int DEPTH = 4;
`ifdef MEM_ARB_DATA_PRIO_EN
  localparam bit PRIO = 1'b1;
`else
  localparam bit PRIO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_arbiter_if #(.Xlen(32), .MaskBits(4)) imem_if ();
  mem_arbiter_if #(.Xlen(32), .MaskBits(4)) dmem_if ();
  mem_arbiter_if #(.Xlen(32), .MaskBits(4)) mem_if ();

  mem_arbiter #(.Xlen(32), .MaskBits(4), .Depth(DEPTH)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .imem  (imem_if),
    .dmem  (dmem_if),
    .mem   (mem_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Requester and memory stimulus state.
  bit          iv, dv, mrdy, rvld;
  logic [31:0] ia, iw, da, dw, rdat;
  logic [3:0]  im, dm;

  // Reference model: who the rules say is granted, plus outstanding sources.
  bit m_pref_data = 1'b1;
  bit m_locked    = 1'b0;
  bit m_lock_port = 1'b0;
  bit m_out [$];
  bit m_gv, m_gport, m_acc;

  // Expected responses {port, data}; port 1 = data side.
  logic [32:0] exp_q [$];

  // Observations captured by the last cycle.
  logic        obs_valid;
  logic [31:0] obs_addr;
  logic [1:0]  obs_gnt;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic new_i();
    ia = $urandom; iw = $urandom; im = 4'($urandom);
  endtask

  task automatic new_d();
    da = $urandom; dw = $urandom; dm = 4'($urandom);
  endtask

  task automatic run_cycle();
    imem_if.valid = iv; imem_if.addr = ia; imem_if.wdata = iw; imem_if.wmask = im;
    dmem_if.valid = dv; dmem_if.addr = da; dmem_if.wdata = dw; dmem_if.wmask = dm;
    mem_if.ready  = mrdy; mem_if.rvalid = rvld; mem_if.rdata = rdat;
    if (rvld && m_out.size() > 0) exp_q.push_back({m_out[0], rdat});
    @(negedge clk);
    m_gv = 1'b0;
    m_gport = 1'b0;
    if (m_locked) begin
      m_gv = 1'b1;
      m_gport = m_lock_port;
    end else if (m_out.size() < DEPTH && (iv || dv)) begin
      m_gv = 1'b1;
      m_gport = (iv && dv) ? (PRIO ? 1'b1 : m_pref_data) : dv;
    end
    m_acc = m_gv && mrdy;
    obs_valid = mem_if.valid;
    obs_addr  = mem_if.addr;
    obs_gnt   = {dmem_if.ready, imem_if.ready};
    check("mem_valid", mem_if.valid, m_gv);
    check("mem_payload", {mem_if.addr, mem_if.wdata, mem_if.wmask},
          !m_gv ? 68'h0 : (m_gport ? {da, dw, dm} : {ia, iw, im}));
    check("port_ready", obs_gnt, {m_acc && m_gport, m_acc && !m_gport});
    @(posedge clk);
    #1;
    if (rvld && m_out.size() > 0) void'(m_out.pop_front());
    if (m_acc) begin
      m_out.push_back(m_gport);
      m_pref_data = !m_gport;
      m_locked = 1'b0;
      if (m_gport) dv = 1'b0; else iv = 1'b0;
    end else if (m_gv) begin
      m_locked = 1'b1;
      m_lock_port = m_gport;
    end
  endtask

  // Complete pending requests and drain all outstanding responses.
  task automatic settle();
    bit done = 1'b0;
    mrdy = 1'b1;
    for (int k = 0; k < 40 && !done; k++) begin
      rvld = (m_out.size() > 0);
      rdat = $urandom;
      run_cycle();
      done = !iv && !dv && (m_out.size() == 0);
    end
    rvld = 1'b0;
    if (!done) begin
      n_checks++; n_errors++;
      $display("FAIL settle_timeout: outstanding %0d expected 0", m_out.size());
    end
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {mem_if.valid, imem_if.ready, dmem_if.ready, imem_if.rvalid, dmem_if.rvalid,
                 mem_if.addr, imem_if.rdata, dmem_if.rdata}, 0);
  endtask

  // Response monitor: every routed response must match the scoreboard head.
  always @(negedge clk) begin
    logic [32:0] e;
    if (!rst) begin
      if (imem_if.rvalid || dmem_if.rvalid) begin
        if (exp_q.size() == 0) begin
          n_checks++; n_errors++;
          $display("FAIL spurious_rvalid: got i=%0b d=%0b expected none at %0t",
                   imem_if.rvalid, dmem_if.rvalid, $time);
        end else begin
          e = exp_q.pop_front();
          check("resp_port", {dmem_if.rvalid, imem_if.rvalid}, e[32] ? 2'b10 : 2'b01);
          check("resp_data", e[32] ? dmem_if.rdata : imem_if.rdata, e[31:0]);
          check("resp_other_zero", e[32] ? imem_if.rdata : dmem_if.rdata, 0);
        end
      end else if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_checks++; n_errors++;
        $display("FAIL missing_rvalid: got none expected port %0d data %0h at %0t",
                 e[32], e[31:0], $time);
      end else begin
        check("idle_rdata", {imem_if.rdata, dmem_if.rdata}, 0);
      end
    end
  end

  initial begin
    logic [1:0] exp_rr [4];
    iv = 1'b1; dv = 1'b1; mrdy = 1'b1; rvld = 1'b1; rdat = 32'h1234_5678;
    new_i(); new_d();
    imem_if.valid = iv; imem_if.addr = ia; imem_if.wdata = iw; imem_if.wmask = im;
    dmem_if.valid = dv; dmem_if.addr = da; dmem_if.wdata = dw; dmem_if.wmask = dm;
    mem_if.ready = mrdy; mem_if.rvalid = rvld; mem_if.rdata = rdat;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention right after reset: data preferred first.
    for (int i = 0; i < 4; i++) exp_rr[i] = (PRIO || (i % 2 == 0)) ? 2'b10 : 2'b01;
    rvld = 1'b0; mrdy = 1'b1; iv = 1'b1; dv = 1'b1; new_i(); new_d();
    for (int i = 0; i < 4; i++) begin
      run_cycle();
      check("contention_grant", obs_gnt, exp_rr[i]);
      if (i < 3) begin
        if (!iv) begin iv = 1'b1; new_i(); end
        if (!dv) begin dv = 1'b1; new_d(); end
      end
    end
    if (!iv) iv = 1'b0;
    dv = dv && PRIO ? 1'b0 : dv;
    iv = 1'b0; dv = 1'b0;
    settle();

    // Single instruction read.
    iv = 1'b1; ia = 32'h100; iw = 32'h0; im = 4'h0; mrdy = 1'b1;
    run_cycle();
    check("single_grant", obs_gnt, 2'b01);
    check("single_addr", obs_addr, 32'h100);
    run_cycle();
    rvld = 1'b1; rdat = 32'hDEAD_BEEF;
    run_cycle();
    rvld = 1'b0;

    // Stall lock: inst held while data arrives.
    iv = 1'b1; ia = 32'h200; iw = 32'h0; im = 4'h0; mrdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check("stall_addr", obs_addr, 32'h200);
      check("stall_no_ready", obs_gnt, 2'b00);
      if (i == 0) begin dv = 1'b1; da = 32'h300; dw = 32'h55; dm = 4'hF; end
    end
    mrdy = 1'b1;
    run_cycle();
    check("stall_inst_grant", obs_gnt, 2'b01);
    run_cycle();
    check("stall_data_grant", obs_gnt, 2'b10);
    settle();

    // FIFO full.
    mrdy = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      dv = 1'b1; new_d();
      run_cycle();
      check("fill_grant", obs_gnt, 2'b10);
    end
    dv = 1'b1; new_d();
    run_cycle();
    check("full_block", {obs_valid, obs_gnt}, 3'b000);
    rvld = 1'b1; rdat = $urandom;
    run_cycle();
    check("full_pop_cycle", {obs_valid, obs_gnt}, 3'b000);
    rvld = 1'b0;
    run_cycle();
    check("full_resume", {obs_valid, obs_gnt}, 3'b110);
    settle();

    // Reset with two requests in flight.
    mrdy = 1'b1; iv = 1'b1; dv = 1'b1; new_i(); new_d();
    run_cycle();
    run_cycle();
    check("midflight_outstanding", m_out.size(), 2);
    iv = 1'b1; dv = 1'b1; rvld = 1'b1;
    imem_if.valid = 1'b1; dmem_if.valid = 1'b1; mem_if.rvalid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("midflight_reset_outputs");
    @(posedge clk); #1;
    rst = 1'b0;
    m_out.delete(); m_locked = 1'b0; m_pref_data = 1'b1;
    iv = 1'b0; dv = 1'b0; rvld = 1'b1; rdat = 32'hBAD0_0001;
    run_cycle();
    run_cycle();
    rvld = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      if (!iv && $urandom_range(0, 1) == 1) begin iv = 1'b1; new_i(); end
      if (!dv && $urandom_range(0, 1) == 1) begin dv = 1'b1; new_d(); end
      mrdy = ($urandom_range(0, 3) != 0);
      rvld = (m_out.size() > 0) && ($urandom_range(0, 1) == 1);
      rdat = $urandom;
      run_cycle();
    end
    settle();
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
